// File: rtl/la_control.sv
// Wishbone slave for logic-analyzer control: team select mux for the 128-bit LA bus,
// plus a delayed, software-triggered snapshot of that bus readable as four words.
`timescale 1ns/1ps

module la_snap_lane #(
  parameter int VEC_W = 32
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             latch,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  always_ff @(posedge gclk) begin
    if (grst)       dout <= '0;
    else if (latch) dout <= din;
  end
endmodule

module la_control #(
  parameter int NUM_TEAMS = 12
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic [NUM_TEAMS:0][127:0]   designs_la_data_out,
  output logic [127:0]                la_data_out
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;
  localparam int SW        = $clog2(NUM_TEAMS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  // word offsets (byte address >> 2)
  localparam logic [13:0] W_SEL   = 14'd0;
  localparam logic [13:0] W_CTRL  = 14'd1;
  localparam logic [13:0] W_COUNT = 14'd2;
  localparam logic [13:0] W_DELAY = 14'd3;

  logic                              req, wr;
  logic [13:0]                       widx;
  logic [7:0]                        sel_q;
  logic [15:0]                       delay_q, count_q, timer_q;
  logic [0:0]                        state_q;
  logic                              busy, latch;
  logic [31:0]                       rdata;
  logic [NUM_LANES-1:0][VEC_W-1:0]   snap, la_vec;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:16], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  assign req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr    = req & wbs_we_i;
  assign widx  = wbs_adr_i[15:2];
  assign busy  = (state_q == ST_COUNT);
  assign latch = busy && (timer_q == 16'd0);

  assign la_data_out = designs_la_data_out[sel_q[SW-1:0]];
  assign la_vec      = la_data_out;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      la_snap_lane #(.VEC_W(VEC_W)) u_lane (
        .gclk (wb_clk_i),
        .grst (wb_rst_i),
        .latch(latch),
        .din  (la_vec[g]),
        .dout (snap[g])
      );
    end
  endgenerate

  always_comb begin
    rdata = '0;
    case (widx)
      W_SEL:   rdata[7:0]  = sel_q;
      W_CTRL:  rdata[1]    = busy;
      W_COUNT: rdata[15:0] = count_q;
      W_DELAY: rdata[15:0] = delay_q;
      default: if (widx[13:2] == 12'd1) rdata = snap[widx[1:0]];
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      sel_q     <= '0;
      delay_q   <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;

      // out-of-range team indices are dropped so the mux never selects a missing team
      if (wr && widx == W_SEL && wbs_sel_i[0] && wbs_dat_i[7:0] <= 8'(NUM_TEAMS))
        sel_q <= wbs_dat_i[7:0];
      if (wr && widx == W_DELAY && wbs_sel_i[0]) delay_q[7:0]  <= wbs_dat_i[7:0];
      if (wr && widx == W_DELAY && wbs_sel_i[1]) delay_q[15:8] <= wbs_dat_i[15:8];

      case (state_q)
        ST_IDLE: begin
          if (wr && widx == W_CTRL && wbs_sel_i[0] && wbs_dat_i[0]) begin
            state_q <= ST_COUNT;
            timer_q <= delay_q;
          end
        end
        default: begin
          if (timer_q != 16'd0) begin
            timer_q <= timer_q - 16'd1;
          end else begin
            state_q <= ST_IDLE;
            count_q <= count_q + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_la_control.sv
// Directed bench for la_control: register access, team select clamping, delayed capture,
// busy collisions, mid-capture reset, COUNT wrap and unmapped offsets.
`timescale 1ns/1ps

module tb_la_control;
  localparam int NT = 12;

  logic                 clk = 1'b0, rst = 1'b1;
  logic                 stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]           sel = '0;
  logic [31:0]          adr = '0, wdat = '0;
  logic                 ack;
  logic [31:0]          rdat;
  logic [NT:0][127:0]   des;
  logic [127:0]         la;

  int          n_chk = 0, n_fail = 0;
  logic        dyn = 1'b0;
  logic [31:0] tick = '0;
  logic [31:0] e_tick = '0;

  always #5 clk = ~clk;
  always @(negedge clk) tick <= tick + 32'd1;

  function automatic logic [127:0] pat(input int t);
    logic [127:0] p;
    logic [7:0]   tb8;
    tb8 = t[7:0];
    for (int w = 0; w < 4; w++) p[w*32 +: 32] = {tb8, w[7:0], 16'hC0DE};
    return p;
  endfunction

  function automatic logic [127:0] dynpat(input logic [31:0] c);
    return {c ^ 32'hDDDD0000, c ^ 32'hCCCC0000, c ^ 32'hBBBB0000, c ^ 32'hAAAA0000};
  endfunction

  always_comb begin
    for (int t = 0; t <= NT; t++) des[t] = pat(t);
    if (dyn) des[5] = dynpat(tick);
  end

  la_control #(.NUM_TEAMS(NT)) dut (
    .wb_clk_i           (clk),
    .wb_rst_i           (rst),
    .wbs_stb_i          (stb),
    .wbs_cyc_i          (cyc),
    .wbs_we_i           (we),
    .wbs_sel_i          (sel),
    .wbs_adr_i          (adr),
    .wbs_dat_i          (wdat),
    .wbs_ack_o          (ack),
    .wbs_dat_o          (rdat),
    .designs_la_data_out(des),
    .la_data_out        (la)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // one access: drive at negedge, ack edge records tick, sample at following negedge
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    check("idle", {95'd0, ack, rdat}, '0);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    e_tick = tick;
    @(negedge clk);
    check("ack", {127'd0, ack}, 128'd1);
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_access(1'b1, a, d, s, r);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, a, 32'd0, 4'd0, r);
    check(tag, {96'd0, r}, {96'd0, exp});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp;
    logic [31:0]  e;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {127'd0, ack}, '0);
    check("rst_dat", {96'd0, rdat}, '0);
    rst = 1'b0;
    rd("rst_sel",   32'h0,  32'h0);
    rd("rst_ctrl",  32'h4,  32'h0);
    rd("rst_count", 32'h8,  32'h0);
    rd("rst_delay", 32'hC,  32'h0);
    rd("rst_snap0", 32'h10, 32'h0);
    check("rst_la", la, pat(0));

    // SEL update and clamping
    wr(32'h0, 32'd5, 4'hF);
    check("la_t5", la, pat(5));
    rd("sel5", 32'h0, 32'd5);
    wr(32'h0, 32'd13, 4'hF);
    rd("sel_clamp", 32'h0, 32'd5);
    wr(32'h0, 32'd7, 4'h0);
    rd("sel_nobe", 32'h0, 32'd5);
    wr(32'h0, 32'd12, 4'h1);
    rd("sel12", 32'h0, 32'd12);
    check("la_t12", la, pat(12));
    wr(32'h0, 32'd5, 4'h1);

    // DELAY byte enables
    wr(32'hC, 32'h0000_0003, 4'hF);
    wr(32'hC, 32'hABCD_7777, 4'hC);
    rd("delay_nobe", 32'hC, 32'h3);
    wr(32'hC, 32'h0000_1299, 4'b0010);
    rd("delay_hi", 32'hC, 32'h1203);
    wr(32'hC, 32'h0000_0003, 4'b0011);

    // delayed capture of a moving pattern
    dyn = 1'b1;
    wr(32'h4, 32'h1, 4'h1);
    e = e_tick;
    rd("cap_busy", 32'h4, 32'h2);
    repeat (6) @(negedge clk);
    exp = dynpat(e + 32'd4);
    rd("cap_snap0", 32'h10, exp[31:0]);
    rd("cap_snap1", 32'h14, exp[63:32]);
    rd("cap_snap2", 32'h18, exp[95:64]);
    rd("cap_snap3", 32'h1C, exp[127:96]);
    rd("cap_count", 32'h8, 32'd1);
    rd("cap_ctrl",  32'h4, 32'h0);
    dyn = 1'b0;

    // busy collision, plus DELAY and SEL writes while busy
    wr(32'hC, 32'd10, 4'h3);
    wr(32'h4, 32'h1, 4'h1);
    wr(32'h4, 32'h1, 4'h1);
    wr(32'hC, 32'd1, 4'h3);
    wr(32'h0, 32'd3, 4'h1);
    repeat (3) @(negedge clk);
    rd("col_busy_last", 32'h4, 32'h2);
    rd("col_done",      32'h4, 32'h0);
    rd("col_count",     32'h8, 32'd2);
    exp = pat(3);
    rd("col_snap0", 32'h10, exp[31:0]);
    rd("col_delay", 32'hC, 32'd1);
    wr(32'h0, 32'd5, 4'h1);

    // reset in the middle of a capture
    wr(32'hC, 32'd20, 4'h3);
    wr(32'h4, 32'h1, 4'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd("mid_snap0", 32'h10, 32'h0);
    rd("mid_snap3", 32'h1C, 32'h0);
    rd("mid_count", 32'h8, 32'h0);
    rd("mid_ctrl",  32'h4, 32'h0);
    rd("mid_sel",   32'h0, 32'h0);
    repeat (30) @(negedge clk);
    rd("mid_count_late", 32'h8, 32'h0);
    rd("mid_snap_late",  32'h10, 32'h0);

    // COUNT wrap with DELAY=0 and strobe held continuously
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h4; wdat = 32'h1; sel = 4'h1;
    repeat (2 * 65535) @(posedge clk);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    rd("count_ffff", 32'h8, 32'hFFFF);
    wr(32'h4, 32'h1, 4'h1);
    repeat (2) @(negedge clk);
    rd("count_wrap", 32'h8, 32'h0);
    exp = pat(0);
    rd("wrap_snap3", 32'h1C, exp[127:96]);

    // unmapped offsets
    rd("unmap_20",  32'h20,  32'h0);
    rd("unmap_104", 32'h104, 32'h0);
    wr(32'h20, 32'hFFFF_FFFF, 4'hF);
    rd("unmap_sel",   32'h0, 32'h0);
    rd("unmap_delay", 32'hC, 32'h0);
    rd("unmap_count", 32'h8, 32'h0);
    rd("unmap_ctrl",  32'h4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
